// File: rtl/mem_arbiter.sv
// Arbitrates an instruction-fetch port and a load/store port onto one 256-word memory,
// returning one-cycle responses, flagging out-of-range addresses and counting grants.
module mem_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_req,
  input  logic [31:0]      i_addr,
  output logic             i_gnt,
  output logic             i_rvalid,
  output logic [31:0]      i_rdata,
  output logic             i_err,
  input  logic             d_req,
  input  logic             d_we,
  input  logic [31:0]      d_addr,
  input  logic [31:0]      d_wdata,
  input  logic [3:0]       d_mask,
  output logic             d_gnt,
  output logic             d_rvalid,
  output logic [31:0]      d_rdata,
  output logic             d_err,
  output logic             mem_request,
  output logic             mem_we_re,
  output logic [7:0]       mem_address,
  output logic [31:0]      mem_data_in,
  output logic [3:0]       mem_mask,
  input  logic [31:0]      mem_data_out,
  output logic [CNT_W-1:0] i_grant_cnt,
  output logic [CNT_W-1:0] d_grant_cnt
);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

  localparam logic             PORT_I  = 1'b0;
  localparam logic             PORT_D  = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1'b1);

  state_t           state_r;
  logic             last_grant_r;
  logic             resp_port_r;
  logic             resp_we_r;
  logic             resp_err_r;
  logic [CNT_W-1:0] i_cnt_r;
  logic [CNT_W-1:0] d_cnt_r;

  logic             raw_i_s;
  logic             raw_d_s;
  logic             raw_grant_s;
  logic             grant_s;
  logic [31:0]      sel_addr_s;
  logic             oor_s;
  logic             resp_rd_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  // Arbitration ignoring reset: a lone requester wins, a collision goes to the port not granted last.
  always_comb begin
    raw_i_s = 1'b0;
    raw_d_s = 1'b0;
    if (i_req && d_req) begin
      if (last_grant_r == PORT_D) begin
        raw_i_s = 1'b1;
      end else begin
        raw_d_s = 1'b1;
      end
    end else begin
      raw_i_s = i_req;
      raw_d_s = d_req;
    end
  end

  assign i_gnt       = raw_i_s & rst;
  assign d_gnt       = raw_d_s & rst;
  assign grant_s     = i_gnt | d_gnt;
  assign raw_grant_s = raw_i_s | raw_d_s;
  assign sel_addr_s  = raw_d_s ? d_addr : i_addr;
  assign oor_s       = |sel_addr_s[31:10];

  // Memory command: only an in-range grant reaches the memory, everything else drives zeros.
  always_comb begin
    mem_request = 1'b0;
    mem_we_re   = 1'b0;
    mem_address = 8'h00;
    mem_data_in = 32'h0000_0000;
    mem_mask    = 4'h0;
    if (grant_s && !oor_s) begin
      mem_request = 1'b1;
      mem_address = sel_addr_s[9:2];
      if (d_gnt) begin
        mem_we_re   = d_we;
        mem_data_in = d_wdata;
        mem_mask    = d_mask;
      end else begin
        mem_we_re   = 1'b0;
        mem_data_in = 32'h0000_0000;
        mem_mask    = 4'h0;
      end
    end else begin
      mem_request = 1'b0;
    end
  end

  // Response strobes; read data comes straight from the memory's registered output.
  always_comb begin
    resp_rd_s = !resp_err_r && !resp_we_r;
    i_rvalid  = (state_r == RESP) && (resp_port_r == PORT_I);
    d_rvalid  = (state_r == RESP) && (resp_port_r == PORT_D);
    i_err     = i_rvalid & resp_err_r;
    d_err     = d_rvalid & resp_err_r;
    i_rdata   = (i_rvalid && resp_rd_s) ? mem_data_out : 32'h0000_0000;
    d_rdata   = (d_rvalid && resp_rd_s) ? mem_data_out : 32'h0000_0000;
  end

  // Response FSM, arbitration history and saturating grant counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= IDLE;
      last_grant_r <= PORT_D;
      resp_port_r  <= PORT_I;
      resp_we_r    <= 1'b0;
      resp_err_r   <= 1'b0;
      i_cnt_r      <= '0;
      d_cnt_r      <= '0;
    end else begin
      case (state_r)
        IDLE:    state_r <= raw_grant_s ? RESP : IDLE;
        RESP:    state_r <= raw_grant_s ? RESP : IDLE;
        default: state_r <= IDLE;
      endcase
      if (raw_grant_s) begin
        last_grant_r <= raw_d_s ? PORT_D : PORT_I;
        resp_port_r  <= raw_d_s ? PORT_D : PORT_I;
        resp_we_r    <= raw_d_s & d_we;
        resp_err_r   <= oor_s;
        if (raw_d_s) begin
          d_cnt_r <= sat_inc(d_cnt_r);
        end else begin
          i_cnt_r <= sat_inc(i_cnt_r);
        end
      end else begin
        last_grant_r <= last_grant_r;
      end
    end
  end

  assign i_grant_cnt = i_cnt_r;
  assign d_grant_cnt = d_cnt_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural model checks every output each cycle,
// and hand-computed literals pin the key scenarios.
module tb_mem_arbiter;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             i_req = 1'b0;
  logic [31:0]      i_addr = 32'h0;
  logic             d_req = 1'b0;
  logic             d_we = 1'b0;
  logic [31:0]      d_addr = 32'h0;
  logic [31:0]      d_wdata = 32'h0;
  logic [3:0]       d_mask = 4'h0;
  logic [31:0]      mem_data_out = 32'h0;
  logic             i_gnt, i_rvalid, i_err, d_gnt, d_rvalid, d_err;
  logic [31:0]      i_rdata, d_rdata;
  logic             mem_request, mem_we_re;
  logic [7:0]       mem_address;
  logic [31:0]      mem_data_in;
  logic [3:0]       mem_mask;
  logic [CNT_W-1:0] i_grant_cnt, d_grant_cnt;

  logic [31:0] env_mem [256];
  logic [31:0] ref_mem [256];

  int n_vec  = 0;
  int n_miss = 0;

  logic        m_last_data = 1'b1;
  int          m_ic = 0;
  int          m_dc = 0;
  logic        m_pv = 1'b0;
  logic        m_pport = 1'b0;
  logic        m_perr = 1'b0;
  logic [31:0] m_pdata = 32'h0;

  typedef struct packed {
    logic        ir;
    logic [31:0] ia;
    logic        dr;
    logic        dwe;
    logic [31:0] da;
    logic [31:0] dwd;
    logic [3:0]  dm;
  } vec_t;

  vec_t tbl [5] = '{
    '{1'b0, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_03FC, 32'hA5A5_5A5A, 4'b1100},
    '{1'b1, 32'h0000_03FC, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0000},
    '{1'b1, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0000},
    '{1'b0, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_03FF, 32'h0000_0000, 4'b0000},
    '{1'b0, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, 32'h0000_0000, 4'b0000}
  };

  mem_arbiter #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid),
    .i_rdata(i_rdata), .i_err(i_err),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_mask(d_mask),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_address(mem_address),
    .mem_data_in(mem_data_in), .mem_mask(mem_mask), .mem_data_out(mem_data_out),
    .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int k);
    return (k == 4) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | 32'(k));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] m);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++) if (m[b]) res[8*b +: 8] = wd[8*b +: 8];
    return res;
  endfunction

  // Data wins when it is the only requester, or on a collision when fetch went last.
  function automatic logic pick_d(input logic ir, input logic dr, input logic last_d);
    return dr && (!ir || !last_d);
  endfunction

  function automatic int sat(input int c);
    return (c >= CNT_MAX) ? CNT_MAX : c + 1;
  endfunction

  function automatic logic [31:0] resp_data(input logic is_d);
    logic [31:0] a;
    a = is_d ? d_addr : i_addr;
    if (a[31:10] != 22'd0) return 32'h0;
    if (is_d && d_we) return 32'h0;
    return ref_mem[a[9:2]];
  endfunction

  // Memory environment: registered read, byte-masked write.
  always @(posedge clk) begin
    if (mem_request) begin
      if (mem_we_re) env_mem[mem_address] <= merge(env_mem[mem_address], mem_data_in, mem_mask);
      else mem_data_out <= env_mem[mem_address];
    end
  end

  // Reference model: one transaction per grant, answered on the following cycle.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_last_data <= 1'b1;
      m_ic <= 0;
      m_dc <= 0;
      m_pv <= 1'b0;
      m_pport <= 1'b0;
      m_perr <= 1'b0;
      m_pdata <= 32'h0;
    end else if (i_req || d_req) begin
      m_pv        <= 1'b1;
      m_pport     <= pick_d(i_req, d_req, m_last_data);
      m_last_data <= pick_d(i_req, d_req, m_last_data);
      m_perr      <= pick_d(i_req, d_req, m_last_data) ? (d_addr[31:10] != 22'd0)
                                                       : (i_addr[31:10] != 22'd0);
      m_pdata     <= resp_data(pick_d(i_req, d_req, m_last_data));
      if (pick_d(i_req, d_req, m_last_data)) m_dc <= sat(m_dc);
      else m_ic <= sat(m_ic);
      if (pick_d(i_req, d_req, m_last_data) && d_we && d_addr[31:10] == 22'd0)
        ref_mem[d_addr[9:2]] <= merge(ref_mem[d_addr[9:2]], d_wdata, d_mask);
    end else begin
      m_pv <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic compare_cycle();
    logic        gi, gd, inr, ri, rd;
    logic [31:0] a;
    gd  = rst && pick_d(i_req, d_req, m_last_data);
    gi  = rst && i_req && !gd;
    a   = gd ? d_addr : i_addr;
    inr = (gi || gd) && (a[31:10] == 22'd0);
    ri  = m_pv && !m_pport;
    rd  = m_pv && m_pport;
    check("i_gnt", i_gnt, gi);
    check("d_gnt", d_gnt, gd);
    check("mem_request", mem_request, inr);
    check("mem_we_re", mem_we_re, inr && gd && d_we);
    check("mem_address", mem_address, inr ? a[9:2] : 8'h00);
    check("mem_data_in", mem_data_in, (inr && gd) ? d_wdata : 32'h0);
    check("mem_mask", mem_mask, (inr && gd) ? d_mask : 4'h0);
    check("i_rvalid", i_rvalid, ri);
    check("i_err", i_err, ri && m_perr);
    check("i_rdata", i_rdata, ri ? m_pdata : 32'h0);
    check("d_rvalid", d_rvalid, rd);
    check("d_err", d_err, rd && m_perr);
    check("d_rdata", d_rdata, rd ? m_pdata : 32'h0);
    check("i_grant_cnt", i_grant_cnt, m_ic);
    check("d_grant_cnt", d_grant_cnt, m_dc);
  endtask

  always @(negedge clk) compare_cycle();

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      env_mem[k] = init_word(k);
      ref_mem[k] = init_word(k);
    end
    #1 rst = 1'b0;
    cyc();
    i_req = 1'b1; i_addr = 32'h0000_0010;
    #1 check("reset_no_gnt", i_gnt, 1'b0);
    check("reset_cnt", i_grant_cnt, 4'h0);
    cyc();
    cyc();
    i_req = 1'b0; rst = 1'b1;

    // Collision after reset: fetch, data, fetch, then the held data request.
    cyc();
    i_req = 1'b1; i_addr = 32'h0000_0010; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0020;
    #1 check("coll1_i_gnt", i_gnt, 1'b1);
    check("coll1_d_gnt", d_gnt, 1'b0);
    cyc();
    #1 check("coll2_d_gnt", d_gnt, 1'b1);
    check("coll2_i_rdata", i_rdata, 32'hDEAD_BEEF);
    cyc();
    #1 check("coll3_i_gnt", i_gnt, 1'b1);
    check("coll3_d_rdata", d_rdata, 32'hC0DE_0008);
    cyc();
    i_req = 1'b0;
    #1 check("coll4_d_gnt", d_gnt, 1'b1);
    check("coll4_i_rvalid", i_rvalid, 1'b1);
    cyc();
    d_req = 1'b0;
    #1 check("coll_i_cnt", i_grant_cnt, 4'd2);
    check("coll_d_cnt", d_grant_cnt, 4'd2);

    // Single fetch.
    cyc();
    i_req = 1'b1; i_addr = 32'h0000_0010;
    #1 check("fetch_addr", mem_address, 8'h04);
    check("fetch_we", mem_we_re, 1'b0);
    cyc();
    i_req = 1'b0;
    #1 check("fetch_rdata", i_rdata, 32'hDEAD_BEEF);
    check("fetch_err", i_err, 1'b0);

    // Masked store, then a back-to-back load of the same word.
    cyc();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0008; d_wdata = 32'h1122_3344; d_mask = 4'b0011;
    #1 check("store_mask", mem_mask, 4'b0011);
    check("store_addr", mem_address, 8'h02);
    cyc();
    d_we = 1'b0; d_wdata = 32'h0; d_mask = 4'h0;
    #1 check("store_rvalid", d_rvalid, 1'b1);
    check("store_rdata", d_rdata, 32'h0);
    cyc();
    d_req = 1'b0;
    #1 check("load_low_half", d_rdata[15:0], 16'h3344);
    check("load_word", d_rdata, 32'hC0DE_3344);

    // Out-of-range data access.
    cyc();
    d_req = 1'b1; d_addr = 32'h0000_0400;
    #1 check("oor_gnt", d_gnt, 1'b1);
    check("oor_mem_request", mem_request, 1'b0);
    cyc();
    d_req = 1'b0;
    #1 check("oor_err", d_err, 1'b1);
    check("oor_cnt", d_grant_cnt, 4'd5);

    // Mixed boundary vectors.
    for (int k = 0; k < 5; k++) begin
      cyc();
      i_req = tbl[k].ir; i_addr = tbl[k].ia; d_req = tbl[k].dr; d_we = tbl[k].dwe;
      d_addr = tbl[k].da; d_wdata = tbl[k].dwd; d_mask = tbl[k].dm;
      #1 if (k == 2) check("fetch_after_store", i_rdata, 32'hA5A5_00FF);
    end

    // Reset between a read grant and its response.
    cyc();
    i_req = 1'b1; i_addr = 32'h0000_0010;
    #1 check("midrst_gnt", i_gnt, 1'b1);
    #1 rst = 1'b0;
    #1 check("midrst_gnt_off", i_gnt, 1'b0);
    check("midrst_i_cnt", i_grant_cnt, 4'h0);
    check("midrst_d_cnt", d_grant_cnt, 4'h0);
    i_req = 1'b0;
    cyc();
    rst = 1'b1;
    #1 check("midrst_no_rvalid", i_rvalid, 1'b0);
    cyc();
    i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0030;
    #1 check("midrst_coll_fetch", i_gnt, 1'b1);
    cyc();
    i_req = 1'b0;
    #1 check("midrst_coll_data", d_gnt, 1'b1);
    cyc();
    d_req = 1'b0;

    // Saturation of the fetch counter.
    for (int k = 0; k < 17; k++) begin
      cyc();
      i_req = 1'b1; i_addr = 32'(k) << 2;
    end
    cyc();
    i_req = 1'b0;
    #1 check("sat_i_cnt", i_grant_cnt, 4'hF);
    cyc();
    cyc();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of each per-port grant counter.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports i_req in 1, i_addr in 32: instruction-fetch read request and byte address.
REQ-005 SHALL have ports i_gnt out 1, i_rvalid out 1, i_rdata out 32, i_err out 1: fetch grant, response strobe, read data, error flag.
REQ-006 SHALL have ports d_req in 1, d_we in 1, d_addr in 32, d_wdata in 32, d_mask in 4: load/store request, write-enable (1 = write), byte address, write data, byte-lane mask.
REQ-007 SHALL have ports d_gnt out 1, d_rvalid out 1, d_rdata out 32, d_err out 1: data-port grant, response strobe, read data, error flag.
REQ-008 SHALL have ports mem_request out 1, mem_we_re out 1, mem_address out 8, mem_data_in out 32, mem_mask out 4: memory command.
REQ-009 SHALL have port mem_data_out in 32: memory read data, registered inside the memory, valid one cycle after a read command.
REQ-010 SHALL have ports i_grant_cnt out CNT_W, d_grant_cnt out CNT_W: per-port grant counters.

Function
REQ-011 SHALL, when exactly one of i_req/d_req is high and no reset is active, assert that port's gnt combinationally in the same cycle.
REQ-012 SHALL, when i_req and d_req are both high, grant the port not granted most recently; last_grant resets to "data", so the first collision goes to fetch.
REQ-013 SHALL assert at most one of i_gnt/d_gnt in any cycle and update last_grant only on a grant.
REQ-014 SHALL, in a grant cycle with an in-range address, drive mem_request=1, mem_address=addr[9:2], and for fetch: mem_we_re=0, mem_mask=0, mem_data_in=0; for data: mem_we_re=d_we, mem_mask=d_mask, mem_data_in=d_wdata.
REQ-015 SHALL hold mem_request=0 and all other mem_* outputs at 0 in every cycle without an in-range grant.
REQ-016 SHALL treat an address as out-of-range when addr[31:10] != 0; it is still granted but mem_request stays 0.
REQ-017 SHALL run a two-state FSM: IDLE (no response pending) and RESP (response due this cycle); a grant moves to RESP, else the FSM goes to IDLE.
REQ-018 SHALL, in RESP, pulse exactly one rvalid for one cycle on the port granted the previous cycle; reads return rdata=mem_data_out, writes return rdata=0.
REQ-019 SHALL, for an out-of-range grant, return rvalid=1, err=1, rdata=0 in RESP; err=0 otherwise.
REQ-020 SHALL hold rvalid=0, err=0 and rdata=0 on any port with no response in the current cycle.
REQ-021 SHALL allow a new grant in a RESP cycle; back-to-back grants every cycle are permitted; read-to-response latency is exactly 1 cycle.
REQ-022 SHALL require each requester to hold req and all request fields stable until it sees gnt; req asserted in the grant cycle's successor is a new request.
REQ-023 SHALL increment the granted port's counter by 1 per grant, including out-of-range grants, and saturate at all-ones.

Reset
REQ-024 SHALL, while rst=0, force gnt/rvalid/err/rdata/mem_* outputs to 0, counters to 0, FSM to IDLE and last_grant to "data", independent of clk.
REQ-025 SHALL discard any pending response when reset asserts mid-operation; no rvalid is produced after rst deasserts for a grant issued before reset.
REQ-026 SHALL issue no grant in the cycle rst is low; the first grant can occur in the first clk edge cycle after rst goes high.

Verification
REQ-027 Single fetch: i_req=1, i_addr=0x0000_0010, mem[4]=0xDEADBEEF -> i_gnt same cycle, mem_address=0x04, mem_we_re=0; next cycle i_rvalid=1, i_rdata=0xDEADBEEF, i_err=0.
REQ-028 Collision: i_req=d_req=1 for 3 grants after reset -> grant order fetch, data, fetch; one rvalid per cycle on the matching port.
REQ-029 Masked store: d_we=1, d_addr=0x0000_0008, d_wdata=0x11223344, d_mask=4'b0011 -> mem_mask=0011, mem_address=0x02; next cycle d_rvalid=1, d_rdata=0; subsequent load returns low half 0x3344.
REQ-030 Out-of-range: d_req=1, d_addr=0x0000_0400 -> d_gnt=1, mem_request=0; next cycle d_rvalid=1, d_err=1, d_rdata=0; d_grant_cnt increments.
REQ-031 Reset mid-operation: grant a read, drop rst low before the response edge -> no i_rvalid after release, counters read 0, first collision goes to fetch.
REQ-032 Saturation: CNT_W=4, 17 fetch grants -> i_grant_cnt stops at 4'hF.
